// File: rtl/bus_mux_reg_if.sv
// rtl/bus_mux_reg_if.sv - bus source / registered bus bundle for bus_mux_reg
// Purpose: groups the source words, drive enables, error clear and the
//   registered bus plus conflict status into one port.
// Signals:
//   src_data        flattened source words, source i at [i*WIDTH +: WIDTH]
//   src_out         per-source drive enables
//   err_clr         synchronous clear of conflict_sticky / conflict_cnt
//   bus_out         registered bus value
//   bus_valid       bus_out was driven by a source last cycle
//   bus_sel         index of the driving source, all-ones when idle
//   conflict        last cycle had two or more enables
//   conflict_sticky conflict seen since the last clear/err_clr
//   conflict_cnt    saturating count of conflict cycles
// Modports: master = source/consumer side, slave = bus_mux_reg.
interface bus_mux_reg_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_out;
  logic                     err_clr;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic [SEL_W-1:0]         bus_sel;
  logic                     conflict;
  logic                     conflict_sticky;
  logic [CNT_W-1:0]         conflict_cnt;

  modport master (
    output src_data, src_out, err_clr,
    input  bus_out, bus_valid, bus_sel, conflict, conflict_sticky, conflict_cnt
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output bus_out, bus_valid, bus_sel, conflict, conflict_sticky, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// rtl/bus_mux_reg.sv - registered priority bus multiplexer with conflict tracking
// Purpose: selects the lowest-index requesting source onto a registered bus
//   (one cycle latency) and reports multi-driver conflicts.
// Ports:
//   clock   rising-edge clock
//   clear   asynchronous active-high reset
//   bus_if  bus_mux_reg_if.slave (sources in, registered bus/status out)
module bus_mux_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int HOLD_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic           clock,
  input  logic           clear,
  bus_mux_reg_if.slave   bus_if
);

  localparam logic [SEL_W-1:0] SEL_IDLE = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Encoder outputs
  logic [SEL_W-1:0] enc_sel;
  logic [WIDTH-1:0] enc_data;
  logic             enc_any;
  logic             enc_multi;

  // State
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             conflict_q, conflict_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_base;

  // Lowest-index priority: the first set bit wins; any later set bit
  // marks a multi-driver cycle. Data is picked inside the loop so an idle
  // select code never indexes past the source array.
  always_comb begin
    enc_sel   = SEL_IDLE;
    enc_data  = '0;
    enc_any   = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus_if.src_out[i]) begin
        if (enc_any) begin
          enc_multi = 1'b1;
        end else begin
          enc_any  = 1'b1;
          enc_sel  = SEL_W'(i);
          enc_data = bus_if.src_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    bus_d      = bus_q;
    valid_d    = enc_any;
    sel_d      = SEL_IDLE;
    conflict_d = enc_multi;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    cnt_base   = cnt_q;

    if (enc_any) begin
      bus_d = enc_data;
      sel_d = enc_sel;
    end else if (HOLD_EN == 0) begin
      bus_d = '0;
    end

    // err_clr clears first, then a conflict in the same cycle sets again,
    // so a coincident clear and conflict leaves sticky=1, cnt=1.
    if (bus_if.err_clr) begin
      sticky_d = 1'b0;
      cnt_base = '0;
      cnt_d    = '0;
    end
    if (enc_multi) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      sel_q      <= SEL_IDLE;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_if.bus_out         = bus_q;
  assign bus_if.bus_valid       = valid_q;
  assign bus_if.bus_sel         = sel_q;
  assign bus_if.conflict        = conflict_q;
  assign bus_if.conflict_sticky = sticky_q;
  assign bus_if.conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// tb/tb_bus_mux_reg.sv - scoreboard bench for bus_mux_reg (hold/8-bit and zero/4-bit builds)
module tb_bus_mux_reg;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SEL_W = 5;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic [NSRC*WIDTH-1:0] src_data = '0;
  logic [NSRC-1:0]       src_out  = '0;
  logic                  err_clr  = 1'b0;

  always #5 clock = ~clock;

  bus_mux_reg_if #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SEL_W), .CNT_W(8)) if_a ();
  bus_mux_reg_if #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SEL_W), .CNT_W(4)) if_b ();

  assign if_a.src_data = src_data;
  assign if_a.src_out  = src_out;
  assign if_a.err_clr  = err_clr;
  assign if_b.src_data = src_data;
  assign if_b.src_out  = src_out;
  assign if_b.err_clr  = err_clr;

  bus_mux_reg #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SEL_W), .HOLD_EN(1), .CNT_W(8))
    dut_a (.clock(clock), .clear(clear), .bus_if(if_a));
  bus_mux_reg #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SEL_W), .HOLD_EN(0), .CNT_W(4))
    dut_b (.clock(clock), .clear(clear), .bus_if(if_b));

  typedef struct {
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        valid;
    logic [4:0]  sel;
    logic        conf;
    logic        sticky;
    logic [7:0]  cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] m_bus_a = '0;
  logic [31:0] m_bus_b = '0;
  logic        m_sticky = 1'b0;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_bus_a = '0; m_bus_b = '0; m_sticky = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // Predicts the outputs after the coming edge and queues them.
  task automatic predict();
    exp_t e;
    int   sel;
    int   nset;
    sel  = -1;
    nset = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_out[i]) begin
        nset++;
        if (sel < 0) sel = i;
      end
    end
    if (clear) begin
      model_reset();
      e.valid = 1'b0; e.sel = 5'd31; e.conf = 1'b0;
    end else begin
      if (sel >= 0) begin
        m_bus_a = src_data[sel*WIDTH +: WIDTH];
        m_bus_b = src_data[sel*WIDTH +: WIDTH];
      end else begin
        m_bus_b = '0;
      end
      if (err_clr) begin
        m_sticky = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
      end
      if (nset >= 2) begin
        m_sticky = 1'b1;
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 15)  m_cnt_b++;
      end
      e.valid = (sel >= 0);
      e.sel   = (sel >= 0) ? 5'(sel) : 5'd31;
      e.conf  = (nset >= 2);
    end
    e.bus_a  = m_bus_a;
    e.bus_b  = m_bus_b;
    e.sticky = m_sticky;
    e.cnt_a  = 8'(m_cnt_a);
    e.cnt_b  = 4'(m_cnt_b);
    sb_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    check_eq({tag, ".bus_a"},    if_a.bus_out, e.bus_a);
    check_eq({tag, ".bus_b"},    if_b.bus_out, e.bus_b);
    check_eq({tag, ".valid_a"},  32'(if_a.bus_valid), 32'(e.valid));
    check_eq({tag, ".valid_b"},  32'(if_b.bus_valid), 32'(e.valid));
    check_eq({tag, ".sel_a"},    32'(if_a.bus_sel), 32'(e.sel));
    check_eq({tag, ".sel_b"},    32'(if_b.bus_sel), 32'(e.sel));
    check_eq({tag, ".conf_a"},   32'(if_a.conflict), 32'(e.conf));
    check_eq({tag, ".conf_b"},   32'(if_b.conflict), 32'(e.conf));
    check_eq({tag, ".sticky_a"}, 32'(if_a.conflict_sticky), 32'(e.sticky));
    check_eq({tag, ".sticky_b"}, 32'(if_b.conflict_sticky), 32'(e.sticky));
    check_eq({tag, ".cnt_a"},    32'(if_a.conflict_cnt), 32'(e.cnt_a));
    check_eq({tag, ".cnt_b"},    32'(if_b.conflict_cnt), 32'(e.cnt_b));
  endtask

  // Drive one cycle's inputs, predict, then sample #1 after the edge.
  task automatic cycle(input string tag, input logic [NSRC-1:0] so, input logic ec);
    src_out = so;
    err_clr = ec;
    predict();
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    src_data[idx*WIDTH +: WIDTH] = w;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NSRC; i++) set_word(i, $urandom);
  endtask

  logic [NSRC-1:0] so_r;

  initial begin
    // Reset held across several edges with random inputs
    for (int k = 0; k < 3; k++) begin
      randomize_data();
      cycle("reset", NSRC'($urandom), 1'b1);
    end
    clear = 1'b0;

    // Single source at every index, PC (20) carries 0x1234
    for (int i = 0; i < NSRC; i++) begin
      set_word(i, (i == 20) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(i * 257 + 1)));
      cycle("single", NSRC'(1) << i, 1'b0);
    end

    // Priority plus conflict: R3 beats Zlow
    set_word(3, 32'hAAAA_0003);
    set_word(19, 32'h5555_0013);
    cycle("prio_conf", (NSRC'(1) << 3) | (NSRC'(1) << 19), 1'b0);
    cycle("post_conf_idle", '0, 1'b0);

    // Idle hold (build A) versus idle zero (build B)
    set_word(7, 32'hDEAD_BEEF);
    cycle("drive_beef", NSRC'(1) << 7, 1'b0);
    cycle("idle_hold", '0, 1'b0);
    cycle("idle_hold2", '0, 1'b0);

    // 20 conflict cycles: 4-bit counter pins at 15
    for (int k = 0; k < 20; k++) cycle("sat", NSRC'(24'h00_0003), 1'b0);
    check_eq("sat_cnt_b_15", 32'(if_b.conflict_cnt), 32'd15);

    // err_clr alone, then err_clr coinciding with a conflict
    cycle("errclr_only", NSRC'(1) << 2, 1'b1);
    cycle("errclr_conf", NSRC'(24'h80_0001), 1'b1);
    check_eq("errclr_conf_cnt", 32'(if_a.conflict_cnt), 32'd1);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      randomize_data();
      case ($urandom_range(0, 2))
        0: so_r = '0;
        1: so_r = NSRC'(1) << $urandom_range(0, NSRC - 1);
        default: so_r = NSRC'($urandom);
      endcase
      cycle("rand", so_r, ($urandom_range(0, 5) == 0));
    end

    // Mid-cycle asynchronous reset: outputs drop before any edge
    cycle("pre_rst", NSRC'(24'h00_0030), 1'b0);
    #3 clear = 1'b1;
    #1;
    check_eq("async_rst.bus_a",  if_a.bus_out, 32'h0);
    check_eq("async_rst.sel_a",  32'(if_a.bus_sel), 32'd31);
    check_eq("async_rst.valid",  32'(if_a.bus_valid), 32'd0);
    check_eq("async_rst.sticky", 32'(if_a.conflict_sticky), 32'd0);
    check_eq("async_rst.cnt_a",  32'(if_a.conflict_cnt), 32'd0);
    model_reset();
    clear = 1'b0;
    set_word(11, 32'h0BAD_F00D);
    cycle("post_rst", NSRC'(1) << 11, 1'b0);
    cycle("post_rst_idle", '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
